// File: rtl/rom_fetch_unit_if.sv
// rom_fetch_unit_if
// Bundles the ROM bus, the decode handshake and the branch redirect inputs
// of the instruction fetch unit.
//   master : the fetch unit (drives ADDR/CS/OE and INSTR/INSTR_PC/INSTR_VALID)
//   slave  : the ROM + decode + execute side
// FAULT exists only when FETCH_BOUND_CHECK_EN is defined.
interface rom_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  FETCH_EN;
  logic                  BRANCH_EN;
  logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic                  CS;
  logic                  OE;
  logic [DATA_WIDTH-1:0] DATA;
  logic [DATA_WIDTH-1:0] INSTR;
  logic [ADDR_WIDTH-1:0] INSTR_PC;
  logic                  INSTR_VALID;
  logic                  INSTR_READY;
`ifdef FETCH_BOUND_CHECK_EN
  logic                  FAULT;
`endif

  modport master (
    input  FETCH_EN, BRANCH_EN, BRANCH_ADDR, DATA, INSTR_READY,
    output ADDR, CS, OE, INSTR, INSTR_PC, INSTR_VALID
`ifdef FETCH_BOUND_CHECK_EN
    , output FAULT
`endif
  );

  modport slave (
    output FETCH_EN, BRANCH_EN, BRANCH_ADDR, DATA, INSTR_READY,
    input  ADDR, CS, OE, INSTR, INSTR_PC, INSTR_VALID
`ifdef FETCH_BOUND_CHECK_EN
    , input FAULT
`endif
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit
// Instruction fetch initiator: sequences the PC, drives a registered
// ADDR / CS (active-low) / OE (active-high) to the ROM, waits WAIT_CYCLES
// extra cycles, captures DATA and offers it to decode on a valid/ready
// handshake. BRANCH_EN redirects the PC from any state.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : rom_fetch_unit_if.master (ROM bus, decode handshake, redirect)
// Optional: FETCH_BOUND_CHECK_EN adds FAULT and refuses fetches at
// PC >= ROM_WORDS.
module rom_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int unsigned           WAIT_CYCLES = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           ROM_WORDS   = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  rom_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic                  cs, cs_n;
  logic                  oe, oe_n;
  logic [3:0]            cnt, cnt_n;
  logic [DATA_WIDTH-1:0] instr, instr_n;
  logic [ADDR_WIDTH-1:0] instr_pc, instr_pc_n;
  logic                  valid, valid_n;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] launch_addr;
  logic                  fetch_ok;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ROM_LIMIT = ADDR_WIDTH'(ROM_WORDS);
  logic fault, fault_n;
  assign fetch_ok  = bus.FETCH_EN && !fault;
  assign bus.FAULT = fault;
`else
  assign fetch_ok  = bus.FETCH_EN;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      addr     <= RESET_PC;
      cs       <= 1'b1;
      oe       <= 1'b0;
      cnt      <= '0;
      instr    <= '0;
      instr_pc <= '0;
      valid    <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
      fault    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      addr     <= addr_n;
      cs       <= cs_n;
      oe       <= oe_n;
      cnt      <= cnt_n;
      instr    <= instr_n;
      instr_pc <= instr_pc_n;
      valid    <= valid_n;
`ifdef FETCH_BOUND_CHECK_EN
      fault    <= fault_n;
`endif
    end
  end

  // Every path that starts a ROM access funnels through launch/launch_addr
  // so the bound check and the ADDR/CS/OE/counter load live in one place.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    addr_n      = addr;
    cs_n        = cs;
    oe_n        = oe;
    cnt_n       = cnt;
    instr_n     = instr;
    instr_pc_n  = instr_pc;
    valid_n     = valid;
    launch      = 1'b0;
    launch_addr = pc;
`ifdef FETCH_BOUND_CHECK_EN
    fault_n     = fault;
`endif

    if (bus.BRANCH_EN) begin
      // Redirect aborts any access and drops a pending instruction; a
      // coincident handshake is simply treated as consumed.
      pc_n        = bus.BRANCH_ADDR;
      valid_n     = 1'b0;
      state_n     = IDLE;
      cs_n        = 1'b1;
      oe_n        = 1'b0;
      launch      = bus.FETCH_EN;
      launch_addr = bus.BRANCH_ADDR;
`ifdef FETCH_BOUND_CHECK_EN
      if (bus.BRANCH_ADDR < ROM_LIMIT) fault_n = 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          launch = fetch_ok;
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt_n = cnt - 4'd1;
          end else begin
            instr_n    = bus.DATA;
            instr_pc_n = pc;
            valid_n    = 1'b1;
            pc_n       = pc + 1'b1;
            cs_n       = 1'b1;
            oe_n       = 1'b0;
            state_n    = HOLD;
          end
        end
        HOLD: begin
          if (valid && bus.INSTR_READY) begin
            valid_n = 1'b0;
            state_n = IDLE;
            launch  = fetch_ok;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (launch) begin
`ifdef FETCH_BOUND_CHECK_EN
      if (launch_addr >= ROM_LIMIT) begin
        fault_n = 1'b1;
        state_n = IDLE;
        cs_n    = 1'b1;
        oe_n    = 1'b0;
      end else
`endif
      begin
        state_n = ACCESS;
        addr_n  = launch_addr;
        cs_n    = 1'b0;
        oe_n    = 1'b1;
        cnt_n   = WAIT_LOAD;
      end
    end
  end

  assign bus.ADDR        = addr;
  assign bus.CS          = cs;
  assign bus.OE          = oe;
  assign bus.INSTR       = instr;
  assign bus.INSTR_PC    = instr_pc;
  assign bus.INSTR_VALID = valid;

endmodule

// File: tb/tb_rom_fetch_unit.sv
module tb_rom_fetch_unit;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int unsigned W    = 1;
  localparam logic [31:0] RPC  = 32'h10;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef FETCH_BOUND_CHECK_EN
  localparam int unsigned RW = 32'h50;
`else
  localparam int unsigned RW = 1024;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rom_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W),
    .RESET_PC(RPC), .ROM_WORDS(RW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return a < RW;
`else
    return a == a;
`endif
  endfunction

  // ROM model: drives junk whenever it is not selected and enabled.
  always_comb bus.DATA = (!bus.CS && bus.OE) ? rom_word(bus.ADDR) : JUNK;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.FETCH_EN    = 1'b0;
    bus.BRANCH_EN   = 1'b0;
    bus.BRANCH_ADDR = '0;
    bus.INSTR_READY = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.CS, bus.OE, bus.INSTR_VALID} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctl: cs/oe/valid=%b want 100", {bus.CS, bus.OE, bus.INSTR_VALID});
    end
    checks++;
    if (bus.ADDR !== RPC) begin
      errors++;
      $display("FAIL reset_addr: got %h want %h", bus.ADDR, RPC);
    end
    checks++;
    if ({bus.INSTR, bus.INSTR_PC} !== 64'h0) begin
      errors++;
      $display("FAIL reset_instr: instr=%h pc=%h want 0", bus.INSTR, bus.INSTR_PC);
    end
`ifdef FETCH_BOUND_CHECK_EN
    checks++;
    if (bus.FAULT !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: got %b want 0", bus.FAULT);
    end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    rst = 1'b0; bus.FETCH_EN = 1'b1; bus.INSTR_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = RPC + 32'(k);
      for (int c = 0; c <= int'(W); c++) begin
        tick();
        checks++;
        if ({bus.CS, bus.OE, bus.INSTR_VALID, bus.ADDR} !== {3'b010, a}) begin
          errors++;
          $display("FAIL seq_access%0d_%0d: cs/oe/v=%b addr=%h want 010 %h", k, c,
                   {bus.CS, bus.OE, bus.INSTR_VALID}, bus.ADDR, a);
        end
      end
      tick();
      checks++;
      if ({bus.CS, bus.OE, bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR} !== {3'b101, a, rom_word(a)}) begin
        errors++;
        $display("FAIL seq_capture%0d: cs/oe/v=%b pc=%h instr=%h want 101 %h %h", k,
                 {bus.CS, bus.OE, bus.INSTR_VALID}, bus.INSTR_PC, bus.INSTR, a, rom_word(a));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    rst = 1'b0; bus.FETCH_EN = 1'b1; bus.INSTR_READY = 1'b0;
    repeat (W + 2) tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.CS, bus.OE, bus.INSTR_VALID, bus.ADDR, bus.INSTR_PC, bus.INSTR} !==
          {3'b101, RPC, RPC, rom_word(RPC)}) begin
        errors++;
        $display("FAIL stall_hold%0d: cs/oe/v=%b addr=%h pc=%h instr=%h", i,
                 {bus.CS, bus.OE, bus.INSTR_VALID}, bus.ADDR, bus.INSTR_PC, bus.INSTR);
      end
      if (i < 5) tick();
    end
    bus.INSTR_READY = 1'b1;
    tick();
    checks++;
    if ({bus.CS, bus.INSTR_VALID, bus.ADDR} !== {2'b00, RPC + 32'd1}) begin
      errors++;
      $display("FAIL stall_resume: cs/v=%b addr=%h want 00 %h", {bus.CS, bus.INSTR_VALID},
               bus.ADDR, RPC + 32'd1);
    end
    repeat (W + 1) tick();
    checks++;
    if ({bus.INSTR_VALID, bus.INSTR_PC} !== {1'b1, RPC + 32'd1}) begin
      errors++;
      $display("FAIL stall_next: v=%b pc=%h want 1 %h", bus.INSTR_VALID, bus.INSTR_PC, RPC + 32'd1);
    end
  endtask

  task automatic test_branch();
    do_reset();
    rst = 1'b0; bus.FETCH_EN = 1'b1; bus.INSTR_READY = 1'b1;
    tick();
    tick();
    bus.BRANCH_EN = 1'b1; bus.BRANCH_ADDR = 32'h40;
    tick();
    bus.BRANCH_EN = 1'b0;
    checks++;
    if ({bus.CS, bus.INSTR_VALID, bus.ADDR} !== {2'b00, 32'h40}) begin
      errors++;
      $display("FAIL branch_abort: cs/v=%b addr=%h want 00 00000040", {bus.CS, bus.INSTR_VALID}, bus.ADDR);
    end
    repeat (W) tick();
    tick();
    checks++;
    if ({bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR} !== {1'b1, 32'h40, rom_word(32'h40)}) begin
      errors++;
      $display("FAIL branch_target: v=%b pc=%h instr=%h want 1 00000040 %h", bus.INSTR_VALID,
               bus.INSTR_PC, bus.INSTR, rom_word(32'h40));
    end
  endtask

`ifndef FETCH_BOUND_CHECK_EN
  task automatic test_wrap();
    do_reset();
    rst = 1'b0; bus.FETCH_EN = 1'b1; bus.INSTR_READY = 1'b1;
    bus.BRANCH_EN = 1'b1; bus.BRANCH_ADDR = '1;
    tick();
    bus.BRANCH_EN = 1'b0;
    checks++;
    if ({bus.CS, bus.ADDR} !== {1'b0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_fetch: cs=%b addr=%h want 0 ffffffff", bus.CS, bus.ADDR);
    end
    repeat (W) tick();
    tick();
    checks++;
    if ({bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR} !== {1'b1, 32'hFFFF_FFFF, rom_word(32'hFFFF_FFFF)}) begin
      errors++;
      $display("FAIL wrap_capture: v=%b pc=%h instr=%h", bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR);
    end
    tick();
    checks++;
    if ({bus.CS, bus.ADDR} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wrap_next: cs=%b addr=%h want 0 00000000", bus.CS, bus.ADDR);
    end
  endtask
`endif

  task automatic test_rst_mid();
    do_reset();
    rst = 1'b0; bus.FETCH_EN = 1'b1; bus.INSTR_READY = 1'b1;
    repeat (W + 2) tick();
    repeat (W + 1) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.CS, bus.OE, bus.INSTR_VALID, bus.ADDR, bus.INSTR} !== {3'b100, RPC, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid: cs/oe/v=%b addr=%h instr=%h want 100 %h 0",
               {bus.CS, bus.OE, bus.INSTR_VALID}, bus.ADDR, bus.INSTR, RPC);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.CS, bus.ADDR} !== {1'b0, RPC}) begin
      errors++;
      $display("FAIL rst_restart: cs=%b addr=%h want 0 %h", bus.CS, bus.ADDR, RPC);
    end
  endtask

`ifdef FETCH_BOUND_CHECK_EN
  task automatic test_bound();
    logic [31:0] last;
    last = RW - 1;
    do_reset();
    rst = 1'b0; bus.INSTR_READY = 1'b1;
    bus.FETCH_EN = 1'b1; bus.BRANCH_EN = 1'b1; bus.BRANCH_ADDR = last;
    tick();
    bus.BRANCH_EN = 1'b0;
    checks++;
    if ({bus.CS, bus.FAULT, bus.ADDR} !== {2'b00, last}) begin
      errors++;
      $display("FAIL bound_last: cs/fault=%b addr=%h want 00 %h", {bus.CS, bus.FAULT}, bus.ADDR, last);
    end
    repeat (W) tick();
    tick();
    checks++;
    if ({bus.INSTR_VALID, bus.INSTR_PC} !== {1'b1, last}) begin
      errors++;
      $display("FAIL bound_capture: v=%b pc=%h want 1 %h", bus.INSTR_VALID, bus.INSTR_PC, last);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.CS, bus.OE, bus.INSTR_VALID, bus.FAULT} !== 4'b1001) begin
        errors++;
        $display("FAIL bound_fault%0d: cs/oe/v/fault=%b want 1001", i,
                 {bus.CS, bus.OE, bus.INSTR_VALID, bus.FAULT});
      end
    end
    bus.BRANCH_EN = 1'b1; bus.BRANCH_ADDR = 32'h0;
    tick();
    bus.BRANCH_EN = 1'b0;
    checks++;
    if ({bus.CS, bus.FAULT, bus.ADDR} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL bound_clear: cs/fault=%b addr=%h want 00 0", {bus.CS, bus.FAULT}, bus.ADDR);
    end
    repeat (W) tick();
    tick();
    checks++;
    if ({bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR} !== {1'b1, 32'h0, rom_word(32'h0)}) begin
      errors++;
      $display("FAIL bound_refetch: v=%b pc=%h instr=%h", bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR);
    end
  endtask
`endif

  // Random traffic checked against transaction-level rules: delivered
  // instructions are consecutive words from the last redirect, each access
  // holds CS low for exactly W+1 cycles on a stable address, and captures
  // return the ROM word for that address.
  task automatic test_random();
    logic [31:0] expect_pc, next_fetch, p_addr, p_instr, p_ipc, baddr;
    logic        p_cs, p_valid, p_ready, p_br, p_fetch;
    int unsigned run;
    int          delivered;
    do_reset();
    rst = 1'b0;
    expect_pc = RPC; next_fetch = RPC; run = 0; delivered = 0;
    for (int n = 0; n < 3000 && errors < 20; n++) begin
      p_fetch = ($urandom_range(0, 9) != 0);
      p_ready = $urandom_range(0, 1) == 1;
      p_br    = ($urandom_range(0, 24) == 0);
      baddr   = $urandom_range(0, 32'h7F);
      bus.FETCH_EN = p_fetch; bus.INSTR_READY = p_ready;
      bus.BRANCH_EN = p_br; bus.BRANCH_ADDR = baddr;
      p_cs = bus.CS; p_addr = bus.ADDR; p_valid = bus.INSTR_VALID;
      p_instr = bus.INSTR; p_ipc = bus.INSTR_PC;
      tick();

      checks++;
      if (bus.OE !== !bus.CS) begin
        errors++;
        $display("FAIL rnd_oe: cycle %0d cs=%b oe=%b", n, bus.CS, bus.OE);
      end

      if (p_valid && p_ready) begin
        delivered++;
        checks++;
        if (p_ipc !== expect_pc) begin
          errors++;
          $display("FAIL rnd_order: cycle %0d delivered pc=%h want %h", n, p_ipc, expect_pc);
        end
        expect_pc = expect_pc + 32'd1;
      end

      if (p_br) begin
        expect_pc = baddr; next_fetch = baddr;
        checks++;
        if ({bus.INSTR_VALID, bus.CS} !== {1'b0, !(p_fetch && in_range(baddr))} ||
            (!bus.CS && bus.ADDR !== baddr)) begin
          errors++;
          $display("FAIL rnd_branch: cycle %0d v=%b cs=%b addr=%h target %h fetch=%b", n,
                   bus.INSTR_VALID, bus.CS, bus.ADDR, baddr, p_fetch);
        end
        run = bus.CS ? 0 : 1;
      end else begin
        if (!bus.CS) begin
          checks++;
          if (p_cs) begin
            run = 1;
            if (bus.ADDR !== next_fetch) begin
              errors++;
              $display("FAIL rnd_fetch_addr: cycle %0d addr=%h want %h", n, bus.ADDR, next_fetch);
            end
          end else begin
            run++;
            if (bus.ADDR !== p_addr || run > W + 1) begin
              errors++;
              $display("FAIL rnd_access: cycle %0d addr=%h want %h run=%0d max %0d", n,
                       bus.ADDR, p_addr, run, W + 1);
            end
          end
        end else if (!p_cs) begin
          checks++;
          if (run != W + 1 || {bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR} !== {1'b1, p_addr, rom_word(p_addr)}) begin
            errors++;
            $display("FAIL rnd_capture: cycle %0d run=%0d v=%b pc=%h instr=%h want %0d 1 %h %h", n,
                     run, bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR, W + 1, p_addr, rom_word(p_addr));
          end
          next_fetch = p_addr + 32'd1;
          run = 0;
        end
        if (p_valid && !p_ready) begin
          checks++;
          if ({bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR} !== {1'b1, p_ipc, p_instr}) begin
            errors++;
            $display("FAIL rnd_stable: cycle %0d v=%b pc=%h instr=%h want 1 %h %h", n,
                     bus.INSTR_VALID, bus.INSTR_PC, bus.INSTR, p_ipc, p_instr);
          end
        end
      end
    end
    checks++;
    if (delivered < 50) begin
      errors++;
      $display("FAIL rnd_progress: delivered=%0d want at least 50", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
`ifndef FETCH_BOUND_CHECK_EN
    test_wrap();
`endif
    test_rst_mid();
`ifdef FETCH_BOUND_CHECK_EN
    test_bound();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Initiator side of the instruction ROM interface.
- Sequences the PC and drives ADDR, CS (active-low) and OE (active-high) to the ROM. It waits a programmable access time, then captures DATA into a holding register.
- Presents the captured instruction to the decode stage over a valid/ready handshake.
- Sits between the ROM and the RISCY decode stage. Accepts branch redirects from execute.

Parameters:
- ADDR_WIDTH, 32, width of ADDR, PC and BRANCH_ADDR.
- DATA_WIDTH, 32, width of DATA and INSTR.
- WAIT_CYCLES, 1, extra cycles ADDR/CS/OE are held before DATA is sampled (0..15).
- RESET_PC, 0, PC value loaded on reset.
- ROM_WORDS, 1024, number of valid ROM words. Used only with FETCH_BOUND_CHECK_EN.

Ports:
- CLK  input  1  clock, all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- FETCH_EN  input  1  permits new ROM accesses.
- BRANCH_EN  input  1  one-cycle redirect strobe.
- BRANCH_ADDR  input  ADDR_WIDTH  redirect target.
- ADDR  output  ADDR_WIDTH  ROM word address, registered.
- CS  output  1  ROM chip select, active-low, registered.
- OE  output  1  ROM output enable, active-high, registered.
- DATA  input  DATA_WIDTH  ROM read data. Tristated by the ROM when not selected.
- INSTR  output  DATA_WIDTH  captured instruction.
- INSTR_PC  output  ADDR_WIDTH  address INSTR was fetched from.
- INSTR_VALID  output  1  INSTR/INSTR_PC valid.
- INSTR_READY  input  1  decode accepts INSTR this cycle.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST): evaluated only at the CLK rising edge, overrides everything.
- Reset values: state=IDLE, PC=RESET_PC, ADDR=RESET_PC, CS=1, OE=0, INSTR=0, INSTR_PC=0, INSTR_VALID=0, wait counter=0.
- FSM states: IDLE, ACCESS, HOLD.
- IDLE:
  - CS=1, OE=0.
  - If FETCH_EN=1 -> ACCESS; ADDR<=PC, CS<=0, OE<=1, counter<=WAIT_CYCLES.
- ACCESS:
  - ADDR/CS/OE held stable.
  - If counter!=0: counter decrements.
  - If counter==0 at an edge: INSTR<=DATA, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+1, CS<=1, OE<=0, -> HOLD.
  - Access therefore occupies WAIT_CYCLES+1 cycles with CS low.
- HOLD:
  - INSTR_VALID=1; INSTR and INSTR_PC stable until accepted.
  - On INSTR_VALID&&INSTR_READY: INSTR_VALID<=0.
  - Then: if FETCH_EN=1 -> ACCESS (ADDR<=PC, CS<=0, OE<=1, counter reloaded); else -> IDLE.
  - Throughput with immediate ready: one instruction per WAIT_CYCLES+2 cycles.
- FETCH_EN deasserted mid-ACCESS: the current access completes; no new access starts.
- PC arithmetic: unsigned, modulo 2^ADDR_WIDTH. All-ones wraps to 0.
- BRANCH_EN (any state, highest priority below RST):
  - PC<=BRANCH_ADDR and INSTR_VALID<=0; any ACCESS in progress is aborted.
  - If FETCH_EN=1 -> ACCESS with ADDR<=BRANCH_ADDR, CS<=0, OE<=1, counter reloaded; else -> IDLE with CS<=1, OE<=0.
- BRANCH_EN coincident with INSTR_VALID&&INSTR_READY: the handshake counts as consumed and the branch still applies.
- DATA is sampled only in ACCESS at the final counter edge. DATA is ignored in every other cycle, so a tristated bus is never captured.
- RST mid-ACCESS: CS returns high and OE low on that edge; no capture occurs.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - Adds output FAULT (1 bit, reset 0).
  - When the FSM would enter ACCESS with PC>=ROM_WORDS, it instead holds CS=1 and OE=0, sets FAULT<=1 and goes to IDLE.
  - FAULT stays set until RST or BRANCH_EN to an in-range address.
  - No further accesses are made while FAULT=1.
- Undefined: no FAULT port; ROM_WORDS ignored; all addresses fetched.

Test Plan:
- Reset with RESET_PC=0x10, FETCH_EN=1, WAIT_CYCLES=1, READY=1 -> ADDR=0x10, 0x11, 0x12; INSTR_VALID pulses every 3 cycles; INSTR equals ROM contents; INSTR_PC=0x10, 0x11, 0x12.
- READY=0 for 5 cycles after first capture -> INSTR/INSTR_PC held constant; CS=1, OE=0 throughout; no ADDR change; fetch resumes the cycle after READY=1.
- BRANCH_EN with BRANCH_ADDR=0x40 during second ACCESS cycle -> access aborted, INSTR_VALID=0, next access at ADDR=0x40, next INSTR_PC=0x40.
- PC=0xFFFFFFFF with ADDR_WIDTH=32 -> fetch at 0xFFFFFFFF, next ADDR=0x00000000.
- RST asserted mid-ACCESS -> next edge CS=1, OE=0, INSTR_VALID=0, PC=RESET_PC.
- FETCH_BOUND_CHECK_EN defined, ROM_WORDS=4, start PC=3 -> fetch at 3 succeeds; then FAULT=1, CS stays 1; BRANCH_EN to 0 clears FAULT and fetches 0.
